// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - handshaked ALU with one registered result path and an optional iterative divider
//
// Purpose: arithmetic/logic/compare/shift core that sits between an operand-issue
// stage and a result consumer. It takes one operation per accept
// (IN_VALID & IN_READY) and holds a single registered result until handoff
// (OUT_VALID & OUT_READY). Consumer backpressure stalls issue.
//
// Optional feature macro: ALU_DIV_EN
//   defined   - op 0011 with B!=0 runs a restoring divider (DATA_W+1 cycles)
//   undefined - op 0011 completes single-cycle with ALU_OUT=0, ERR_FLAG=1
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   A, B                operands, sampled on accept
//   ALU_FUN             [3:2] group (arith/logic/cmp/shift), [1:0] op
//   IN_VALID, IN_READY  issue-side handshake
//   ALU_OUT             zero-extended result
//   OUT_GROUP           ALU_FUN[3:2] of the op that produced ALU_OUT
//   CARRY_FLAG          carry / borrow / shifted-out bit
//   ZERO_FLAG           ALU_OUT == 0
//   ERR_FLAG            divide by zero (or divide without a divider)
//   OUT_VALID, OUT_READY consumer-side handshake

module alu_pipe_core #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 2 * DATA_W,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        ALU_FUN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [OUT_W-1:0]  ALU_OUT,
    output logic [1:0]        OUT_GROUP,
    output logic              CARRY_FLAG,
    output logic              ZERO_FLAG,
    output logic              ERR_FLAG,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    if (DATA_W < 2 || OUT_W < 2 * DATA_W || CNT_W < $clog2(DATA_W + 1)) begin : g_param_check
        $error("alu_pipe_core: parameter out of range");
    end

    logic              accept;
    logic              load_single;
    logic              div_done;
    logic [OUT_W-1:0]  div_res;

    // single-cycle datapath
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] prod;
    logic [OUT_W-1:0]    op_res;
    logic                op_carry;
    logic                op_err;

    assign sum    = {1'b0, A} + {1'b0, B};
    assign diff   = A - B;
    assign prod   = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
    assign accept = IN_VALID & IN_READY;

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_err   = 1'b0;
        case (ALU_FUN)
            4'b0000: begin
                op_res[DATA_W:0] = sum;
                op_carry         = sum[DATA_W];
            end
            4'b0001: begin
                op_res[DATA_W-1:0] = diff;
                op_carry           = (A < B);
            end
            4'b0010: op_res[2*DATA_W-1:0] = prod;
            4'b0011: begin
`ifdef ALU_DIV_EN
                // Only loaded when B==0; nonzero divisors go to the divider.
                op_res[2*DATA_W-1:0] = {A, {DATA_W{1'b1}}};
`endif
                op_err = 1'b1;
            end
            4'b0100: op_res[DATA_W-1:0] = A & B;
            4'b0101: op_res[DATA_W-1:0] = A | B;
            4'b0110: op_res[DATA_W-1:0] = ~(A & B);
            4'b0111: op_res[DATA_W-1:0] = ~(A | B);
            4'b1000: op_res = (A == B) ? OUT_W'(1) : '0;
            4'b1001: op_res = (A > B)  ? OUT_W'(2) : '0;
            4'b1010: op_res = (A < B)  ? OUT_W'(3) : '0;
            4'b1011: op_res = '0;
            4'b1100: begin
                op_res[DATA_W-1:0] = {1'b0, A[DATA_W-1:1]};
                op_carry           = A[0];
            end
            4'b1101: begin
                op_res[DATA_W-1:0] = {A[DATA_W-2:0], 1'b0};
                op_carry           = A[DATA_W-1];
            end
            4'b1110: begin
                op_res[DATA_W-1:0] = {1'b0, B[DATA_W-1:1]};
                op_carry           = B[0];
            end
            default: begin
                op_res[DATA_W-1:0] = {B[DATA_W-2:0], 1'b0};
                op_carry           = B[DATA_W-1];
            end
        endcase
    end

`ifdef ALU_DIV_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_q;     // dividend bits shift out MSB-first, quotient bits shift in
    logic [DATA_W-1:0] div_d;
    logic [CNT_W-1:0]  div_cnt;
    logic              div_start;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   trial_sub;
    logic [DATA_W-1:0] nxt_rem;
    logic [DATA_W-1:0] nxt_q;

    assign IN_READY    = (state == ST_IDLE) & (~OUT_VALID | OUT_READY);
    assign div_start   = accept & (ALU_FUN == 4'b0011) & (B != '0);
    assign load_single = accept & ~div_start;

    // trial_sub[DATA_W] set means the shifted remainder is below the divisor.
    assign trial     = {div_rem, div_q[DATA_W-1]};
    assign trial_sub = trial - {1'b0, div_d};
    assign nxt_rem   = trial_sub[DATA_W] ? trial[DATA_W-1:0] : trial_sub[DATA_W-1:0];
    assign nxt_q     = {div_q[DATA_W-2:0], ~trial_sub[DATA_W]};

    // DATA_W iterations run on the edges after accept; the edge after the
    // last iteration loads the result and returns to IDLE.
    assign div_done = (state == ST_DIV) && (div_cnt == CNT_W'(DATA_W));

    always_comb begin
        div_res                  = '0;
        div_res[2*DATA_W-1:0]    = {div_rem, div_q};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            div_rem <= '0;
            div_q   <= '0;
            div_d   <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        state   <= ST_DIV;
                        div_rem <= '0;
                        div_q   <= A;
                        div_d   <= B;
                        div_cnt <= '0;
                    end
                end
                ST_DIV: begin
                    if (div_cnt == CNT_W'(DATA_W)) begin
                        state <= ST_IDLE;
                    end else begin
                        div_rem <= nxt_rem;
                        div_q   <= nxt_q;
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign IN_READY    = ~OUT_VALID | OUT_READY;
    assign load_single = accept;
    assign div_done    = 1'b0;
    assign div_res     = '0;
`endif

    // result registers; a new load on the handoff edge keeps OUT_VALID high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_OUT    <= '0;
            OUT_GROUP  <= 2'b00;
            CARRY_FLAG <= 1'b0;
            ZERO_FLAG  <= 1'b0;
            ERR_FLAG   <= 1'b0;
            OUT_VALID  <= 1'b0;
        end else if (div_done) begin
            ALU_OUT    <= div_res;
            OUT_GROUP  <= 2'b00;
            CARRY_FLAG <= 1'b0;
            ZERO_FLAG  <= (div_res == '0);
            ERR_FLAG   <= 1'b0;
            OUT_VALID  <= 1'b1;
        end else if (load_single) begin
            ALU_OUT    <= op_res;
            OUT_GROUP  <= ALU_FUN[3:2];
            CARRY_FLAG <= op_carry;
            ZERO_FLAG  <= (op_res == '0);
            ERR_FLAG   <= op_err;
            OUT_VALID  <= 1'b1;
        end else if (OUT_READY) begin
            OUT_VALID  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_core.sv
// tb/tb_alu_pipe_core.sv - self-checking bench for alu_pipe_core against a transaction-level model

module tb_alu_pipe_core;

    localparam int W = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [3:0]    ALU_FUN = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [2*W-1:0] ALU_OUT;
    logic [1:0]    OUT_GROUP;
    logic          CARRY_FLAG;
    logic          ZERO_FLAG;
    logic          ERR_FLAG;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;

    alu_pipe_core #(.DATA_W(W)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_OUT(ALU_OUT),
        .OUT_GROUP(OUT_GROUP), .CARRY_FLAG(CARRY_FLAG), .ZERO_FLAG(ZERO_FLAG),
        .ERR_FLAG(ERR_FLAG), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int res;
        bit cy;
        bit er;
    } res_t;

    int   n_checks = 0;
    int   n_errors = 0;

    // model state: the single result slot plus a divide-in-flight countdown
    res_t m_cur;
    res_t m_pend;
    bit   m_valid = 0;
    int   m_busy = 0;
    int   m_grp = 0;
    bit   last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model_op(input int a, input int b, input int f);
        res_t r;
        r.res = 0; r.cy = 0; r.er = 0;
        case (f)
            0:  begin r.res = a + b; r.cy = (a + b) > 255; end
            1:  begin r.res = (a - b + 256) % 256; r.cy = (a < b); end
            2:  r.res = a * b;
            3:  begin
`ifdef ALU_DIV_EN
                if (b == 0) begin r.res = a * 256 + 255; r.er = 1; end
                else r.res = (a % b) * 256 + a / b;
`else
                r.er = 1;
`endif
            end
            4:  r.res = a & b;
            5:  r.res = a | b;
            6:  r.res = 255 - (a & b);
            7:  r.res = 255 - (a | b);
            8:  r.res = (a == b) ? 1 : 0;
            9:  r.res = (a > b) ? 2 : 0;
            10: r.res = (a < b) ? 3 : 0;
            11: r.res = 0;
            12: begin r.res = a / 2;         r.cy = a % 2;  end
            13: begin r.res = (a * 2) % 256; r.cy = a / 128; end
            14: begin r.res = b / 2;         r.cy = b % 2;  end
            default: begin r.res = (b * 2) % 256; r.cy = b / 128; end
        endcase
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", OUT_VALID, m_valid);
        if (m_valid) begin
            chk("alu_out", ALU_OUT, m_cur.res);
            chk("out_group", OUT_GROUP, m_grp);
            chk("carry", CARRY_FLAG, m_cur.cy);
            chk("zero", ZERO_FLAG, m_cur.res == 0);
            chk("err", ERR_FLAG, m_cur.er);
        end
    endtask

    // Called 1 time unit after a rising edge; drives one cycle and checks the result.
    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] f, input bit ordy);
        bit exp_rdy, acc, hand, loaded;
        res_t r;
        IN_VALID = v; A = a; B = b; ALU_FUN = f; OUT_READY = ordy;
        #1;
        exp_rdy = (m_busy == 0) && (!m_valid || ordy);
        chk("in_ready", IN_READY, exp_rdy);
        acc = v && exp_rdy;
        hand = m_valid && ordy;
        last_acc = acc;
        @(posedge CLK);
        #1;
        loaded = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_cur = m_pend; m_grp = 0; loaded = 1;
            end
        end else if (acc) begin
            r = model_op(int'(a), int'(b), int'(f));
`ifdef ALU_DIV_EN
            if (f == 4'b0011 && b != 0) begin
                m_busy = W + 1; m_pend = r;
            end else
`endif
            begin
                m_cur = r; m_grp = int'(f[3:2]); loaded = 1;
            end
        end
        if (loaded) m_valid = 1;
        else if (hand) m_valid = 0;
        check_outputs();
    endtask

    // asynchronous reset asserted mid-cycle, released away from the clock edge
    task automatic do_reset();
        IN_VALID = 0; OUT_READY = 0;
        RST = 1;
        #2;
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_out", ALU_OUT, 0);
        chk("rst_group", OUT_GROUP, 0);
        chk("rst_flags", {CARRY_FLAG, ZERO_FLAG, ERR_FLAG}, 0);
        chk("rst_ready", IN_READY, 1);
        m_valid = 0; m_busy = 0;
        @(negedge CLK);
        RST = 0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hv;
        logic [W-1:0] ha, hb;
        logic [3:0] hf;
        bit ordy;

        @(posedge CLK);
        #1;
        do_reset();

        // ADD carry
        step(1, 8'hFF, 8'h01, 4'b0000, 1);
        chk("add_out", ALU_OUT, 16'h0100);
        chk("add_carry", CARRY_FLAG, 1);
        step(0, 8'h00, 8'h00, 4'b0000, 1);

        // MUL then SUB back to back
        step(1, 8'hFF, 8'hFF, 4'b0010, 1);
        chk("mul_out", ALU_OUT, 16'hFE01);
        step(1, 8'h05, 8'h07, 4'b0001, 1);
        chk("sub_out", ALU_OUT, 16'h00FE);
        chk("sub_borrow", CARRY_FLAG, 1);

        // divide 200/7; operand changes during the divide must not matter
        step(1, 8'd200, 8'd7, 4'b0011, 1);
`ifndef ALU_DIV_EN
        chk("nodiv_out", ALU_OUT, 0);
        chk("nodiv_err", ERR_FLAG, 1);
`endif
        for (int i = 0; i < W + 1; i++) step(0, W'($urandom), W'($urandom), 4'b0011, 1);
`ifdef ALU_DIV_EN
        chk("div_out", ALU_OUT, 16'h041C);
        chk("div_err", ERR_FLAG, 0);
`endif

        // divide by zero
        step(1, 8'h2A, 8'h00, 4'b0011, 1);
`ifdef ALU_DIV_EN
        chk("div0_out", ALU_OUT, 16'h2AFF);
`else
        chk("div0_out", ALU_OUT, 16'h0000);
`endif
        chk("div0_err", ERR_FLAG, 1);

        // backpressure: result held, pending op waits, then handoff+accept together
        step(1, 8'd3, 8'd9, 4'b1010, 1);
        for (int i = 0; i < 5; i++) step(1, 8'd1, 8'd2, 4'b0000, 0);
        chk("bp_hold", ALU_OUT, 16'h0003);
        step(1, 8'd1, 8'd2, 4'b0000, 1);
        chk("bp_next", ALU_OUT, 16'h0003);
        chk("bp_group", OUT_GROUP, 2'b00);

        // reset in the middle of a divide
        step(1, 8'd200, 8'd7, 4'b0011, 1);
        for (int i = 0; i < 4; i++) step(0, 8'd0, 8'd0, 4'b0000, 1);
        do_reset();
        step(1, 8'h81, 8'h00, 4'b1101, 1);
        chk("shl_out", ALU_OUT, 16'h0002);
        chk("shl_carry", CARRY_FLAG, 1);

        // randomized traffic; a refused op is held by the source until taken
        hv = 0; ha = '0; hb = '0; hf = '0;
        for (int i = 0; i < 800; i++) begin
            if (!hv) begin
                hv = ($urandom % 4) != 0;
                ha = W'($urandom);
                hb = W'($urandom);
                hf = 4'($urandom);
                if ($urandom % 8 == 0) hb = '0;
                else if ($urandom % 8 == 0) hb = ha;
            end
            ordy = ($urandom % 4) != 0;
            step(hv, ha, hb, hf, ordy);
            if (last_acc) hv = 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
